key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL provide parameter TICK_HZ, default 1000, debounce sample rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer of at least 2.
REQ-003 SHALL provide parameter STABLE_TICKS, default 20, number of consecutive equal samples needed to accept a level change; legal range 1..255.
REQ-004 clk  input  1  system clock, single clock domain, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 key_n  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to clk.
REQ-007 key_level  output  1  debounced level, 1 = pressed.
REQ-008 press_pulse  output  1  one-clk strobe on accepted press.
REQ-009 release_pulse  output  1  one-clk strobe on accepted release.
REQ-010 led_toggle  output  1  inverts on every accepted press.
REQ-011 press_count  output  8  accepted-press counter.

Function
REQ-012 key_n SHALL pass through a 2-flop synchronizer before any use; pressed_s = ~synchronized key_n.
REQ-013 Tick divider SHALL count 0..CLK_HZ/TICK_HZ-1 and assert tick for one clk when at terminal value, then wrap to 0.
REQ-014 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; all transitions occur only in clk cycles where tick=1.
REQ-015 IDLE: pressed_s=1 at tick -> PRESS_WAIT with stable_cnt=1; if STABLE_TICKS=1, go directly to PRESSED.
REQ-016 PRESS_WAIT: pressed_s=1 at tick -> stable_cnt+1; when stable_cnt reaches STABLE_TICKS -> PRESSED; pressed_s=0 at tick -> IDLE, stable_cnt=0.
REQ-017 PRESSED and RELEASE_WAIT SHALL mirror REQ-015/016 with pressed_s=0 as the qualifying sample, returning to IDLE on acceptance and to PRESSED on a bouncing sample.
REQ-018 key_level SHALL be 1 exactly while state is PRESSED or RELEASE_WAIT.
REQ-019 press_pulse SHALL be 1 for exactly the first clk cycle in which state=PRESSED after a PRESS_WAIT/IDLE entry; release_pulse likewise on entry to IDLE from RELEASE_WAIT; the two SHALL never be simultaneously high.
REQ-020 led_toggle and press_count SHALL update in the same cycle press_pulse is high; press_count SHALL wrap 255 -> 0.
REQ-021 Press detection latency SHALL be 2 clk (sync) plus STABLE_TICKS ticks from a stable input edge, ±1 tick period for phase.
REQ-022 Any bounce shorter than one tick period that is not sampled SHALL have no effect.

Reset
REQ-023 On rst_n=0, asynchronously: state=IDLE, stable_cnt=0, tick divider=0, synchronizer flops=1 (released), all outputs 0.
REQ-024 Reset asserted mid-debounce SHALL abandon the pending transition without emitting any pulse; after release the key is re-qualified from IDLE.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (2-bit) and the derived divider-terminal and counter-width constants.
REQ-026 Tick generation SHALL be a separate sub-module tick_gen (parameters CLK_HZ, TICK_HZ; ports clk, rst_n, tick); everything else stays in key_debounce.

Verification (CLK_HZ=1000, TICK_HZ=100 -> 10 clk/tick, STABLE_TICKS=4)
REQ-027 Clean press held 100 clk -> key_level rises, press_pulse high 1 clk 42..52 clk after edge, press_count=1, led_toggle=1.
REQ-028 Press bouncing 0/1 every 7 clk for 60 clk then stable low -> exactly one press_pulse, none during bounce.
REQ-029 Press then release, each held 80 clk -> one press_pulse, one release_pulse, key_level back to 0, press_count=1.
REQ-030 256 clean presses -> press_count=0, led_toggle=0, 256 press_pulses counted.
REQ-031 rst_n pulsed low while state=PRESS_WAIT (stable_cnt=2) -> no press_pulse, all outputs 0; key still held after release -> press accepted 4 ticks later.
REQ-032 1-clk glitch on key_n away from tick sample points -> no state change, outputs unchanged.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and derived constants for the pushbutton debouncer.
// State encoding plus divider terminal/width helpers.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    localparam int STABLE_W    = 8;
    localparam int PRESS_CNT_W = 8;

    function automatic int div_terminal(input int clk_hz, input int tick_hz);
        return (clk_hz / tick_hz) - 1;
    endfunction

    function automatic int div_width(input int clk_hz, input int tick_hz);
        return ((clk_hz / tick_hz) <= 2) ? 1 : $clog2(clk_hz / tick_hz);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-clk sample strobe.
// Counts 0..terminal and strobes while at terminal.
module tick_gen
    import key_debounce_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int               DIV_W    = div_width(CLK_HZ, TICK_HZ);
    localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(div_terminal(CLK_HZ, TICK_HZ));

    logic [DIV_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == DIV_TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    assign tick = w_term;

endmodule

// File: rtl/key_debounce.sv
// Pushbutton debouncer: sync, tick-sampled qualify FSM,
// press/release strobes, LED toggle and press counter.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int TICK_HZ      = 1000,
    parameter int STABLE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       led_toggle,
    output logic [7:0] press_count
);

    localparam logic [STABLE_W-1:0] STABLE_N = STABLE_W'(STABLE_TICKS);

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   w_pressed_s;
    logic                   w_tick;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [STABLE_W-1:0]    r_stable_cnt;
    logic [STABLE_W-1:0]    w_stable_nxt;
    logic [STABLE_W-1:0]    w_cnt_inc;

    logic                   w_key_level;
    logic                   w_press_evt;
    logic                   w_release_evt;

    logic                   r_press_pulse;
    logic                   r_release_pulse;
    logic                   r_led;
    logic [PRESS_CNT_W-1:0] r_press_cnt;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Idle level of the raw key is high, so the synchronizer resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed_s = ~r_sync2;
    assign w_cnt_inc   = r_stable_cnt + STABLE_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_stable_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_stable_cnt <= w_stable_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_stable_nxt = r_stable_cnt;
        if (w_tick) begin
            unique case (r_state)
                S_IDLE: begin
                    w_stable_nxt = '0;
                    if (w_pressed_s) begin
                        if (STABLE_N == STABLE_W'(1)) begin
                            w_state_nxt = S_PRESSED;
                        end else begin
                            w_state_nxt  = S_PRESS_WAIT;
                            w_stable_nxt = STABLE_W'(1);
                        end
                    end
                end
                S_PRESS_WAIT: begin
                    if (!w_pressed_s) begin
                        w_state_nxt  = S_IDLE;
                        w_stable_nxt = '0;
                    end else if (w_cnt_inc == STABLE_N) begin
                        w_state_nxt  = S_PRESSED;
                        w_stable_nxt = '0;
                    end else begin
                        w_stable_nxt = w_cnt_inc;
                    end
                end
                S_PRESSED: begin
                    w_stable_nxt = '0;
                    if (!w_pressed_s) begin
                        if (STABLE_N == STABLE_W'(1)) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt  = S_RELEASE_WAIT;
                            w_stable_nxt = STABLE_W'(1);
                        end
                    end
                end
                S_RELEASE_WAIT: begin
                    if (w_pressed_s) begin
                        w_state_nxt  = S_PRESSED;
                        w_stable_nxt = '0;
                    end else if (w_cnt_inc == STABLE_N) begin
                        w_state_nxt  = S_IDLE;
                        w_stable_nxt = '0;
                    end else begin
                        w_stable_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_stable_nxt = '0;
                end
            endcase
        end
    end

    // A bounce back from RELEASE_WAIT to PRESSED is not a new press.
    always_comb begin
        w_key_level   = (r_state == S_PRESSED) || (r_state == S_RELEASE_WAIT);
        w_press_evt   = (w_state_nxt == S_PRESSED) &&
                        ((r_state == S_IDLE) || (r_state == S_PRESS_WAIT));
        w_release_evt = (w_state_nxt == S_IDLE) &&
                        ((r_state == S_PRESSED) || (r_state == S_RELEASE_WAIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_led           <= 1'b0;
            r_press_cnt     <= '0;
        end else begin
            r_press_pulse   <= w_press_evt;
            r_release_pulse <= w_release_evt;
            if (w_press_evt) begin
                r_led       <= ~r_led;
                r_press_cnt <= r_press_cnt + PRESS_CNT_W'(1);
            end
        end
    end

    assign key_level     = w_key_level;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign led_toggle    = r_led;
    assign press_count   = r_press_cnt;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce at 10 clk per tick, 4 stable ticks.
// Expected values are hand-derived from the tick phase.
module tb_key_debounce;

    localparam int CLK_HZ       = 1000;
    localparam int TICK_HZ      = 100;
    localparam int STABLE_TICKS = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       led_toggle;
    logic [7:0] press_count;

    int errors = 0;
    int checks = 0;
    int tb_cyc = 0;
    int n_press = 0;
    int n_rel = 0;
    int n_both = 0;

    key_debounce #(
        .CLK_HZ       (CLK_HZ),
        .TICK_HZ      (TICK_HZ),
        .STABLE_TICKS (STABLE_TICKS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_n         (key_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .led_toggle    (led_toggle),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; tick sample edges are multiples of 10.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    always @(negedge clk) begin
        if (press_pulse === 1'b1)   n_press++;
        if (release_pulse === 1'b1) n_rel++;
        if (press_pulse === 1'b1 && release_pulse === 1'b1) n_both++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs,
                             input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int p);
        while ((tb_cyc % 10) != p) @(negedge clk);
    endtask

    task automatic wait_sig(input bit rel, input int bound, output int lat);
        lat = 0;
        while (((rel ? release_pulse : press_pulse) !== 1'b1) && lat < bound) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int base;
        int base_r;

        rst_n = 1'b0;
        key_n = 1'b1;
        clks(3);
        check("rst_level", key_level, 0);
        check("rst_press", press_pulse, 0);
        check("rst_release", release_pulse, 0);
        check("rst_led", led_toggle, 0);
        check("rst_count", press_count, 0);
        rst_n = 1'b1;

        // Clean press at phase 8: first sample at +12, accept 3 ticks later.
        wait_phase(8);
        key_n = 1'b0;
        wait_sig(0, 100, lat);
        check("clean_seen", press_pulse, 1);
        check_rng("clean_lat", lat, 42, 52);
        clks(1);
        check("clean_width", press_pulse, 0);
        check("clean_level", key_level, 1);
        check("clean_count", press_count, 1);
        check("clean_led", led_toggle, 1);
        clks(57);
        key_n = 1'b1;
        wait_sig(1, 100, lat);
        check("rel_seen", release_pulse, 1);
        clks(1);
        check("rel_width", release_pulse, 0);
        check("rel_level", key_level, 0);
        clks(79);
        check("pr_npress", n_press, 1);
        check("pr_nrel", n_rel, 1);
        check("pr_count", press_count, 1);

        // Bounce every 7 clk never gives 4 equal tick samples.
        base = n_press;
        for (int i = 0; i < 60; i++) begin
            key_n = ((i / 7) % 2) != 0;
            @(negedge clk);
        end
        check("bounce_quiet", n_press - base, 0);
        check("bounce_level", key_level, 0);
        key_n = 1'b0;
        wait_sig(0, 80, lat);
        check("bounce_seen", press_pulse, 1);
        clks(40);
        check("bounce_one", n_press - base, 1);
        check("bounce_count", press_count, 2);
        check("bounce_led", led_toggle, 0);
        key_n = 1'b1;
        wait_sig(1, 80, lat);
        check("bounce_rel", release_pulse, 1);
        clks(40);
        check("bounce_rlvl", key_level, 0);

        // One-clk glitch lands on edge phase 6, never a sample edge.
        base = n_press;
        base_r = n_rel;
        wait_phase(3);
        key_n = 1'b0;
        clks(1);
        key_n = 1'b1;
        clks(60);
        check("glitch_level", key_level, 0);
        check("glitch_press", n_press - base, 0);
        check("glitch_rel", n_rel - base_r, 0);
        check("glitch_count", press_count, 2);
        check("glitch_led", led_toggle, 0);

        // Reset while in PRESS_WAIT with two good samples.
        wait_phase(5);
        key_n = 1'b0;
        clks(17);
        base = n_press;
        rst_n = 1'b0;
        clks(2);
        check("mid_level", key_level, 0);
        check("mid_press", press_pulse, 0);
        check("mid_count", press_count, 0);
        check("mid_led", led_toggle, 0);
        check("mid_nopulse", n_press - base, 0);
        rst_n = 1'b1;
        wait_sig(0, 80, lat);
        check("mid_seen", press_pulse, 1);
        check("mid_lat", lat, 40);
        clks(2);
        check("mid_count2", press_count, 1);
        key_n = 1'b1;
        clks(60);

        // 256 presses from reset wrap the counter to 0.
        rst_n = 1'b0;
        clks(2);
        rst_n = 1'b1;
        base = n_press;
        base_r = n_rel;
        for (int i = 0; i < 256; i++) begin
            key_n = 1'b0;
            clks(50);
            key_n = 1'b1;
            clks(50);
            if (i == 254) check("wrap_255", press_count, 255);
        end
        check("wrap_count", press_count, 0);
        check("wrap_led", led_toggle, 0);
        check("wrap_npress", n_press - base, 256);
        check("wrap_nrel", n_rel - base_r, 256);
        check("never_both", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
